result_unloader: RTL

- Downstream of the input memory bank and the 3x3 MAC array.
- When the memory bank raises unload_res, waits a fixed drain time, then snapshots the nine MAC accumulators.
- Streams the valid row_w x col_x sub-matrix out serially in row-major order over a valid/ready handshake.
- Raises done after the last beat.

---
 rtl/result_unloader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// Snapshots the 3x3 MAC accumulators a fixed drain time after unload_res rises and streams the
// valid row_w x col_x block row-major; first beat DRAIN_CYCLES+1 clocks after the edge, beats held while out_ready is low.
module result_unloader #(
  parameter int RES_W        = 10,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_clear_unload,
  input  logic               i_unload_res,
  input  logic [1:0]         i_row_w,
  input  logic [1:0]         i_col_x,
  input  logic [9*RES_W-1:0] i_res_in,
  output logic [RES_W-1:0]   o_data_out,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [1:0]         o_out_row,
  output logic [1:0]         o_out_col,
  output logic               o_out_last,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0]       r_state;
  logic             r_unload_q;
  logic [1:0]       r_rows;
  logic [1:0]       r_cols;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_buf [0:8];
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [RES_W-1:0] r_data;
  logic             r_valid;
  logic             r_last;

  logic       w_start;
  logic       w_xfer;
  logic       w_row_end;
  logic [1:0] w_nxt_row;
  logic [1:0] w_nxt_col;
  logic [3:0] w_nxt_idx;
  logic       w_nxt_last;

  assign w_start    = i_unload_res & ~r_unload_q;
  assign w_xfer     = r_valid & i_out_ready;
  assign w_row_end  = (r_col == r_cols - 2'd1);
  assign w_nxt_row  = w_row_end ? r_row + 2'd1 : r_row;
  assign w_nxt_col  = w_row_end ? 2'd0 : r_col + 2'd1;
  assign w_nxt_idx  = {2'b00, w_nxt_row} * 4'd3 + {2'b00, w_nxt_col};
  assign w_nxt_last = (w_nxt_row == r_rows - 2'd1) && (w_nxt_col == r_cols - 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_clear_unload) begin
      r_state    <= S_IDLE;
      r_unload_q <= 1'b0;
      r_rows     <= 2'd0;
      r_cols     <= 2'd0;
      r_cnt      <= '0;
      r_row      <= 2'd0;
      r_col      <= 2'd0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      for (int k = 0; k < 9; k++) r_buf[k] <= '0;
    end else begin
      r_unload_q <= i_unload_res;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rows  <= i_row_w;
            r_cols  <= i_col_x;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            for (int k = 0; k < 9; k++) r_buf[k] <= i_res_in[k*RES_W +: RES_W];
            if (r_rows == 2'd0 || r_cols == 2'd0) begin
              r_state <= S_DONE;
            end else begin
              // First beat comes straight from res_in so it lines up with the snapshot edge
              r_state <= S_SEND;
              r_row   <= 2'd0;
              r_col   <= 2'd0;
              r_data  <= i_res_in[RES_W-1:0];
              r_valid <= 1'b1;
              r_last  <= (r_rows == 2'd1) && (r_cols == 2'd1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_row  <= w_nxt_row;
              r_col  <= w_nxt_col;
              r_data <= r_buf[w_nxt_idx];
              r_last <= w_nxt_last;
            end
          end
        end
        S_DONE: begin
          if (!i_unload_res) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_out  = r_data;
  assign o_out_valid = r_valid;
  assign o_out_row   = r_row;
  assign o_out_col   = r_col;
  assign o_out_last  = r_last;
  assign o_busy      = (r_state == S_WAIT) || (r_state == S_SEND);
  assign o_done      = (r_state == S_DONE);

endmodule
